// File: rtl/kernel_seq_gen_pkg.sv
// Shared types and constants for the double-buffered kernel sequencer.
// Provides the sequencer state enum, a constant-evaluable clog2 helper and
// default kernel geometry shared with the convolution MAC.
package kernel_pkg;

   localparam int unsigned KERNEL_M_DEF  = 3;
   localparam int unsigned KERNEL_CW_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Ceiling log2, usable in parameter/localparam expressions.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (v > (32'd1 << i)) r = 32'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/kernel_seq_gen_if.sv
// Load stream and kernel output stream of kernel_seq_gen.
// Ports (slave = the sequencer):
//   ld_valid/ld_ready/ld_data : serial coefficient load, row-major order
//   k_valid/k_ready           : coefficient output handshake
//   k_coef/k_row/k_col/k_last : coefficient and its position tags
interface kernel_seq_gen_if
   import kernel_pkg::*;
#(
   parameter int unsigned M  = KERNEL_M_DEF,
   parameter int unsigned CW = KERNEL_CW_DEF
);
   localparam int unsigned RW = clog2(M);

   logic          ld_valid;
   logic          ld_ready;
   logic [CW-1:0] ld_data;
   logic          k_valid;
   logic          k_ready;
   logic [CW-1:0] k_coef;
   logic [RW-1:0] k_row;
   logic [RW-1:0] k_col;
   logic          k_last;

   modport master (
      output ld_valid, ld_data, k_ready,
      input  ld_ready, k_valid, k_coef, k_row, k_col, k_last
   );

   modport slave (
      input  ld_valid, ld_data, k_ready,
      output ld_ready, k_valid, k_coef, k_row, k_col, k_last
   );

endinterface

// File: rtl/kernel_seq_gen_bank.sv
// One M*M x CW coefficient register file.
// Ports: clk, rstn (async clear of all entries), we/waddr/wdata (sync write),
//        raddr/rdata (combinational read).
module kernel_bank
   import kernel_pkg::*;
#(
   parameter  int unsigned M  = KERNEL_M_DEF,
   parameter  int unsigned CW = KERNEL_CW_DEF,
   localparam int unsigned AW = clog2(M * M)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [CW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [CW-1:0] rdata
);

   logic [CW-1:0] mem_q [M*M];

   // Storage with async clear; writer never addresses beyond M*M-1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(M * M); i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/kernel_seq_gen.sv
// Double-buffered M x M kernel store with a row-major output sequencer.
// Ports:
//   clk, rstn      : clock, async active-low reset
//   start          : request one pass over the active kernel
//   kernel_loaded  : a complete kernel has been made active since reset
//   busy           : sequencer is streaming a pass
//   active_bank    : bank currently read by the sequencer
//   bus (slave)    : load stream in, tagged coefficient stream out
module kernel_seq_gen
   import kernel_pkg::*;
#(
   parameter int unsigned M  = KERNEL_M_DEF,
   parameter int unsigned CW = KERNEL_CW_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   output logic              kernel_loaded,
   output logic              busy,
   output logic              active_bank,
   kernel_seq_gen_if.slave   bus
);

   localparam int unsigned AW = clog2(M * M);
   localparam int unsigned RW = clog2(M);

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [RW-1:0] row_q, row_d;
   logic [RW-1:0] col_q, col_d;
   logic [AW-1:0] ld_cnt_q, ld_cnt_d;
   logic          bank_q, bank_d;
   logic          pending_q, pending_d;
   logic          loaded_q, loaded_d;

   logic          ld_fire;
   logic          k_fire;
   logic          idx_last;
   logic          swap;
   logic          we0, we1;
   logic [CW-1:0] rd0, rd1;

   // The shadow bank accepts words until a full kernel waits for a swap.
   assign bus.ld_ready = rstn & ~pending_q;
   assign ld_fire      = bus.ld_valid & bus.ld_ready;

   assign idx_last = (idx_q == AW'(M * M - 1));
   assign k_fire   = bus.k_valid & bus.k_ready;
   assign swap     = (state_q == IDLE) & pending_q;

   // Outputs decoded from registers only.
   assign bus.k_valid = (state_q == RUN);
   assign bus.k_last  = bus.k_valid & idx_last;
   assign bus.k_coef  = bank_q ? rd1 : rd0;
   assign bus.k_row   = row_q;
   assign bus.k_col   = col_q;
   assign busy          = (state_q == RUN);
   assign active_bank   = bank_q;
   assign kernel_loaded = loaded_q;

   // Writes go to the bank not being read.
   assign we0 = ld_fire & bank_q;
   assign we1 = ld_fire & ~bank_q;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
         ld_cnt_q  <= '0;
         bank_q    <= 1'b0;
         pending_q <= 1'b0;
         loaded_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         row_q     <= row_d;
         col_q     <= col_d;
         ld_cnt_q  <= ld_cnt_d;
         bank_q    <= bank_d;
         pending_q <= pending_d;
         loaded_q  <= loaded_d;
      end
   end

   // Next-state: load counter, bank swap and pass sequencer.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      row_d     = row_q;
      col_d     = col_q;
      ld_cnt_d  = ld_cnt_q;
      bank_d    = bank_q;
      pending_d = pending_q;
      loaded_d  = loaded_q;

      if (ld_fire) begin
         if (ld_cnt_q == AW'(M * M - 1)) begin
            ld_cnt_d  = '0;
            pending_d = 1'b1;
         end else begin
            ld_cnt_d = ld_cnt_q + AW'(1);
         end
      end

      // ld_ready is low while pending, so a swap never races a load word.
      if (swap) begin
         bank_d    = ~bank_q;
         pending_d = 1'b0;
         loaded_d  = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (start && (loaded_q || pending_q)) begin
               state_d = RUN;
               idx_d   = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         RUN: begin
            if (k_fire) begin
               if (idx_last) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  row_d   = '0;
                  col_d   = '0;
               end else begin
                  idx_d = idx_q + AW'(1);
                  if (col_q == RW'(M - 1)) begin
                     col_d = '0;
                     row_d = row_q + RW'(1);
                  end else begin
                     col_d = col_q + RW'(1);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   kernel_bank #(.M(M), .CW(CW)) u_bank0 (
      .clk   (clk),
      .rstn  (rstn),
      .we    (we0),
      .waddr (ld_cnt_q),
      .wdata (bus.ld_data),
      .raddr (idx_q),
      .rdata (rd0)
   );

   kernel_bank #(.M(M), .CW(CW)) u_bank1 (
      .clk   (clk),
      .rstn  (rstn),
      .we    (we1),
      .waddr (ld_cnt_q),
      .wdata (bus.ld_data),
      .raddr (idx_q),
      .rdata (rd1)
   );

endmodule

// File: doc/kernel_seq_gen.md
Name: kernel_seq_gen

Overview:
- Parametrised successor to the single-bit kernel memory.
- Stores an M×M kernel of CW-bit signed coefficients in two banks: a shadow bank being loaded and an active bank being read.
- Coefficients are loaded serially over a valid/ready stream.
- On start, a sequencer streams the active kernel out in row-major order with row/col tags under valid/ready.
- Feeds the convolution MAC so a new kernel can be loaded while the current one is in use.

Parameters:
- M, 3, kernel side length; kernel holds M*M entries, M ≥ 2.
- CW, 8, coefficient width in bits (two's complement, passed through untouched).
- AW, clog2(M*M), derived localparam; index width. Not overridable.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- ld_valid  in  1  load word present.
- ld_ready  out  1  shadow bank accepting words.
- ld_data  in  CW  coefficient; word n of a load goes to index n (row-major).
- start  in  1  request one pass over the active kernel.
- kernel_loaded  out  1  at least one complete kernel has been swapped active since reset.
- busy  out  1  sequencer in RUN.
- active_bank  out  1  bank currently read (0/1).
- k_valid  out  1  coefficient output valid.
- k_ready  in  1  downstream accepts.
- k_coef  out  CW  active_bank[idx].
- k_row  out  clog2(M)  idx / M.
- k_col  out  clog2(M)  idx % M.
- k_last  out  1  idx == M*M-1 while k_valid.

Behaviour:
- Reset (rstn low, async):
  - Both banks are cleared to 0.
  - ld_cnt=0, pending=0, active_bank=0, kernel_loaded=0, state=IDLE, idx=row=col=0.
  - All outputs are 0, including ld_ready, which is forced 0 while rstn is low.
  - Reset mid-load or mid-pass discards everything; there is no partial retention.
- Load path:
  - ld_ready = rstn & !pending.
  - On ld_valid & ld_ready: shadow[ld_cnt] <= ld_data and ld_cnt increments.
  - On accepting word M*M-1: ld_cnt wraps to 0, pending <= 1, and ld_ready drops the next cycle.
  - A partial load is never visible to the sequencer.
- Swap:
  - Occurs on any edge where state==IDLE and pending==1.
  - Effects: active_bank toggles, pending <= 0, kernel_loaded <= 1.
  - The shadow becomes the old active bank; new loads overwrite it.
- Sequencer FSM: states IDLE and RUN.
  - IDLE→RUN on start & (kernel_loaded | pending). idx/row/col are set to 0.
  - If a swap happens on the same edge as the start, the pass reads the newly swapped bank.
  - start with nothing loaded is ignored; busy stays 0.
  - RUN: k_valid=1.
    - On k_valid & k_ready, idx increments. col increments and wraps at M-1; on col wrap, row increments.
    - Row and column are held as separate counters; there is no divider.
  - RUN→IDLE on the handshake with k_last=1. k_valid is 0 in the following cycle.
  - start during RUN is ignored and is not queued.
  - Stall: while k_valid & !k_ready, k_coef/k_row/k_col/k_last hold stable.
  - Back-to-back passes cost one IDLE cycle (start sampled in IDLE).
- Swap is blocked during RUN. A load completing mid-pass stays pending until the pass ends, then swaps on the first IDLE edge.
- Latency:
  - start → first k_valid: 1 cycle.
  - Full pass with k_ready held high: M*M cycles.
- Outputs are combinational only from registers (idx, bank contents, state); there is no input→output combinational path except ld_ready from rstn.

Decomposition:
- Package kernel_pkg:
  - state enum {IDLE, RUN}.
  - clog2 helper function.
  - Default M/CW constants shared with the MAC.
- Sub-module kernel_bank (params M, CW): M*M×CW register file with one synchronous write port, one combinational read port, and async clear on rstn.
  - Instantiated twice.
  - Write enable is steered to the shadow bank; read is muxed by active_bank.

Test Plan:
- Reset, then load 1..9 with ld_valid held high → ld_ready falls after the 9th word; swap next cycle; active_bank=1; kernel_loaded=1.
- start with k_ready=1 → 9 beats: k_coef 1..9; (row,col) (0,0)…(2,2); k_last only on the 9th; busy low after.
- Mid-pass stall: drop k_ready on beat 4 for 3 cycles → k_coef=4, row=1, col=0 held stable; pass resumes and completes 9 beats.
- Load 10..18 during a pass → pending held, active_bank unchanged until k_last handshake, then toggles; next pass emits 10..18.
- start before any load, and start during RUN → ignored: busy unchanged, no extra k_valid beats.
- Assert rstn low after 5 load words and again mid-pass → all outputs 0, kernel_loaded=0; a fresh 9-word load is required before start is honoured.
